// File: rtl/vec_addr_gen_pkg.sv
// Shared executor definitions: TAP state encodings, vector address generator FSM states and widths.
package vec_addr_gen_pkg;

    localparam int unsigned ADR_W = 21;
    localparam int unsigned LEN_W = 24;

    typedef enum logic [3:0] {
        TAP_TLR  = 4'h0,
        TAP_RTI  = 4'h1,
        TAP_SDRS = 4'h2,
        TAP_CDR  = 4'h3,
        TAP_SIRS = 4'h4,
        TAP_CIR  = 4'h5,
        TAP_SHDR = 4'h6,
        TAP_SHIR = 4'h7,
        TAP_E1DR = 4'h8,
        TAP_E1IR = 4'h9,
        TAP_PADR = 4'hA,
        TAP_PAIR = 4'hB,
        TAP_E2DR = 4'hC,
        TAP_E2IR = 4'hD,
        TAP_UPDR = 4'hE,
        TAP_UPIR = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } vag_state_e;

    function automatic logic is_shift_state(input logic [3:0] s);
        return (s == TAP_SHDR) || (s == TAP_SHIR);
    endfunction

endpackage

// File: rtl/vec_fetch_timer.sv
// RAM read-wait timer: holds req_o for RD_WAIT cycles and flags the last one with sample_o.
module vec_fetch_timer #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic abort_i,
    output logic req_o,
    output logic sample_o
);

    localparam int unsigned CW = 3;

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d = 1'b1;
            cnt_d = CW'(RD_WAIT - 1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_o    = run_q;
    assign sample_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/vec_addr_gen.sv
// Vector RAM byte-address generator and TDO bit server.
// VEC_ADDR_WRAP_EN: address wraps 21'h1FFFFF->0; otherwise overflow sets err_ovf and ends the scan.
module vec_addr_gen
    import vec_addr_gen_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       state,
    input  logic [ADR_W-1:0] start_adr,
    input  logic [LEN_W-1:0] bit_len,
    input  logic             go,
    input  logic             shift_strb,
    input  logic [7:0]       d_mux,
    output logic [23:3]      a_ag,
    output logic             tdo_req,
    output logic             tdo_bit,
    output logic             busy,
    output logic             done,
    output logic             err_urun,
    output logic             err_ovf
);

    vag_state_e       fsm_q, fsm_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       sel_q, sel_d;
    logic             urun_q, urun_d;
`ifndef VEC_ADDR_WRAP_EN
    logic             ovf_q, ovf_d;
`endif

    logic tmr_start, tmr_abort, tmr_req, tmr_sample;
    logic strb_ok, abort;

    vec_fetch_timer #(
        .RD_WAIT(RD_WAIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (tmr_start),
        .abort_i (tmr_abort),
        .req_o   (tmr_req),
        .sample_o(tmr_sample)
    );

    assign strb_ok = shift_strb && is_shift_state(state);
    assign abort   = (state == TAP_TLR);

    always_comb begin
        fsm_d     = fsm_q;
        adr_d     = adr_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        sel_d     = sel_q;
        urun_d    = urun_q;
`ifndef VEC_ADDR_WRAP_EN
        ovf_d     = ovf_q;
`endif
        tmr_start = 1'b0;
        tmr_abort = 1'b0;

        unique case (fsm_q)
            ST_IDLE: begin
                if (go) begin
                    adr_d     = start_adr;
                    cnt_d     = bit_len;
                    urun_d    = 1'b0;
`ifndef VEC_ADDR_WRAP_EN
                    ovf_d     = 1'b0;
`endif
                    tmr_start = 1'b1;
                    fsm_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    tmr_abort = 1'b1;
                    fsm_d     = ST_IDLE;
                end else begin
                    // A strobe here is lost: flag it but leave the bit counter alone.
                    if (shift_strb) begin
                        urun_d = 1'b1;
                    end
                    if (tmr_sample) begin
                        byte_d = d_mux;
                        sel_d  = '0;
                        fsm_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else if (strb_ok) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    sel_d = sel_q + 3'd1;
                    if (cnt_q == LEN_W'(1)) begin
                        fsm_d = ST_DONE;
                    end else if (sel_q == 3'd7) begin
`ifdef VEC_ADDR_WRAP_EN
                        adr_d     = adr_q + ADR_W'(1);
                        tmr_start = 1'b1;
                        fsm_d     = ST_FETCH;
`else
                        if (adr_q == '1) begin
                            ovf_d = 1'b1;
                            fsm_d = ST_DONE;
                        end else begin
                            adr_d     = adr_q + ADR_W'(1);
                            tmr_start = 1'b1;
                            fsm_d     = ST_FETCH;
                        end
`endif
                    end
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= ST_IDLE;
            adr_q  <= '0;
            cnt_q  <= '0;
            byte_q <= '0;
            sel_q  <= '0;
            urun_q <= 1'b0;
`ifndef VEC_ADDR_WRAP_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            adr_q  <= adr_d;
            cnt_q  <= cnt_d;
            byte_q <= byte_d;
            sel_q  <= sel_d;
            urun_q <= urun_d;
`ifndef VEC_ADDR_WRAP_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign a_ag     = adr_q;
    assign tdo_req  = tmr_req;
    assign tdo_bit  = byte_q[sel_q];
    assign busy     = (fsm_q != ST_IDLE);
    assign done     = (fsm_q == ST_DONE);
    assign err_urun = urun_q;
`ifdef VEC_ADDR_WRAP_EN
    assign err_ovf  = 1'b0;
`else
    assign err_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_vec_addr_gen.sv
// Self-checking bench for vec_addr_gen: vector-position reference model plus directed and random scans.
module tb_vec_addr_gen;
    import vec_addr_gen_pkg::*;

    localparam int unsigned RDW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [20:0] start_adr;
    logic [23:0] bit_len;
    logic        go;
    logic        shift_strb;
    logic [7:0]  d_mux;
    logic [23:3] a_ag;
    logic        tdo_req, tdo_bit, busy, done, err_urun, err_ovf;

    always #5 clk = ~clk;

    vec_addr_gen #(
        .RD_WAIT(RDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .start_adr (start_adr),
        .bit_len   (bit_len),
        .go        (go),
        .shift_strb(shift_strb),
        .d_mux     (d_mux),
        .a_ag      (a_ag),
        .tdo_req   (tdo_req),
        .tdo_bit   (tdo_bit),
        .busy      (busy),
        .done      (done),
        .err_urun  (err_urun),
        .err_ovf   (err_ovf)
    );

    function automatic logic [7:0] ram_byte(input logic [20:0] a);
        if (a == 21'h10) return 8'hA5;
        if (a == 21'h11) return 8'h0C;
        return a[7:0] ^ {a[12:8], a[20:18]} ^ 8'h5A;
    endfunction

    assign d_mux = ram_byte(a_ag);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a scan is a start address, a length and a bit position.
    bit          m_init = 0, m_active = 0, m_done_p = 0, m_urun = 0, m_ovf = 0;
    int          m_wait = 0, m_pos = 0, m_idx = 0;
    int unsigned m_len = 0;
    logic [20:0] m_start = '0;
    int          n_done = 0;
    logic [20:0] fetch_log[$];
    bit          prev_req = 0;

    always @(negedge clk) begin
        logic [20:0] ea;
        logic [7:0]  eb;
        ea = m_start + 21'(m_idx);
        if (m_init) begin
            check("busy", busy, m_active || m_done_p);
            check("tdo_req", tdo_req, m_wait > 0);
            check("done", done, m_done_p);
            check("err_urun", err_urun, m_urun);
            check("err_ovf", err_ovf, m_ovf);
            if (m_active) check("a_ag", a_ag, ea);
            if (m_active && m_wait == 0) begin
                eb = ram_byte(ea);
                check("tdo_bit", tdo_bit, eb[m_pos % 8]);
            end
        end
        if (done === 1'b1) n_done++;
        if (tdo_req === 1'b1 && !prev_req) fetch_log.push_back(a_ag);
        prev_req = (tdo_req === 1'b1);

        if (reset) begin
            m_init = 1; m_active = 0; m_done_p = 0; m_urun = 0; m_ovf = 0;
            m_wait = 0; m_pos = 0; m_idx = 0; m_start = '0; m_len = 0;
        end else if (m_done_p) begin
            m_done_p = 0;
        end else if (!m_active) begin
            if (go) begin
                m_active = 1; m_start = start_adr; m_len = bit_len;
                m_pos = 0; m_idx = 0; m_wait = RDW; m_urun = 0; m_ovf = 0;
            end
        end else if (state == TAP_TLR) begin
            m_active = 0; m_wait = 0;
        end else if (m_wait > 0) begin
            if (shift_strb) m_urun = 1;
            m_wait--;
        end else if (shift_strb && (state == TAP_SHDR || state == TAP_SHIR)) begin
            m_pos++;
            if (m_pos == m_len) begin
                m_active = 0; m_done_p = 1;
            end else if (m_pos % 8 == 0) begin
`ifdef VEC_ADDR_WRAP_EN
                m_idx++; m_wait = RDW;
`else
                if (ea == 21'h1FFFFF) begin
                    m_ovf = 1; m_active = 0; m_done_p = 1;
                end else begin
                    m_idx++; m_wait = RDW;
                end
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go(input logic [20:0] a, input logic [23:0] l);
        start_adr = a;
        bit_len   = l;
        go        = 1'b1;
        cyc();
        go        = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] st);
        state      = st;
        shift_strb = 1'b1;
        cyc();
        shift_strb = 1'b0;
    endtask

    task automatic spaced_strobes(input int n, input logic [3:0] st);
        for (int i = 0; i < n; i++) begin
            repeat (5) cyc();
            strobe(st);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            cyc();
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          f0, d0, k, abort_at, rst_at;
        logic [11:0] got_bits;
        logic [7:0]  eb;
        logic [20:0] a;
        logic [23:0] l;

        reset = 1'b1; state = TAP_RTI; start_adr = '0; bit_len = '0;
        go = 1'b0; shift_strb = 1'b0;
        repeat (3) cyc();
        check("rst_a_ag", a_ag, 0);
        check("rst_tdo_req", tdo_req, 0);
        check("rst_tdo_bit", tdo_bit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err_urun", err_urun, 0);
        check("rst_err_ovf", err_ovf, 0);
        reset = 1'b0;
        cyc();

        // Basic scan: 12 bits from 0x10/0x11, a strobe every 6 cycles.
        f0 = fetch_log.size(); d0 = n_done; state = TAP_SHDR;
        pulse_go(21'h10, 24'd12);
        got_bits = '0;
        for (int i = 0; i < 12; i++) begin
            repeat (5) cyc();
            got_bits[i] = tdo_bit;
            strobe(TAP_SHDR);
        end
        wait_idle(50);
        check("basic_bits", got_bits, 12'hCA5);
        check("basic_fetches", fetch_log.size() - f0, 2);
        if (fetch_log.size() >= f0 + 2) begin
            check("basic_adr0", fetch_log[f0], 21'h10);
            check("basic_adr1", fetch_log[f0+1], 21'h11);
        end
        check("basic_done", n_done - d0, 1);

        // Underrun: a strobe one cycle after the 8th is dropped.
        d0 = n_done;
        pulse_go(21'h100, 24'd16);
        spaced_strobes(8, TAP_SHDR);
        strobe(TAP_SHDR);
        check("urun_set", err_urun, 1);
        spaced_strobes(7, TAP_SHDR);
        repeat (3) cyc();
        check("urun_still_busy", busy, 1);
        check("urun_no_early_done", n_done - d0, 0);
        spaced_strobes(1, TAP_SHDR);
        wait_idle(20);
        check("urun_done", n_done - d0, 1);

        // Abort after 5 strobes of a 20-bit scan, then restart.
        d0 = n_done;
        pulse_go(21'h200, 24'd20);
        spaced_strobes(5, TAP_SHDR);
        state = TAP_TLR;
        cyc();
        state = TAP_SHDR;
        check("abort_busy", busy, 0);
        check("abort_req", tdo_req, 0);
        repeat (3) cyc();
        check("abort_no_done", n_done - d0, 0);
        f0 = fetch_log.size();
        pulse_go(21'h200, 24'd20);
        repeat (2) cyc();
        check("restart_fetch", fetch_log.size() - f0, 1);
        if (fetch_log.size() > f0) check("restart_adr", fetch_log[f0], 21'h200);
        spaced_strobes(20, TAP_SHDR);
        wait_idle(20);
        check("restart_done", n_done - d0, 1);

        // Strobes outside Shift-DR/IR are ignored.
        d0 = n_done;
        pulse_go(21'h300, 24'd10);
        spaced_strobes(2, TAP_SHDR);
        spaced_strobes(3, TAP_PADR);
        eb = ram_byte(21'h300);
        check("gate_tdo_bit", tdo_bit, eb[2]);
        spaced_strobes(7, TAP_SHIR);
        repeat (2) cyc();
        check("gate_busy", busy, 1);
        spaced_strobes(1, TAP_SHDR);
        wait_idle(20);
        check("gate_done", n_done - d0, 1);

        // Reset during the read window.
        state = TAP_SHDR;
        pulse_go(21'h400, 24'd8);
        cyc();
        check("rmf_req_before", tdo_req, 1);
        reset = 1'b1;
        cyc();
        check("rmf_a_ag", a_ag, 0);
        check("rmf_tdo_req", tdo_req, 0);
        check("rmf_tdo_bit", tdo_bit, 0);
        check("rmf_busy", busy, 0);
        check("rmf_done", done, 0);
        reset = 1'b0;
        cyc();

        // Address overflow at the top of the RAM.
        f0 = fetch_log.size(); d0 = n_done;
        pulse_go(21'h1FFFFF, 24'd16);
        spaced_strobes(8, TAP_SHDR);
`ifdef VEC_ADDR_WRAP_EN
        spaced_strobes(8, TAP_SHDR);
        wait_idle(20);
        check("ovf_fetches", fetch_log.size() - f0, 2);
        if (fetch_log.size() >= f0 + 2) check("ovf_wrap_adr", fetch_log[f0+1], 21'h0);
        check("ovf_err", err_ovf, 0);
`else
        wait_idle(20);
        check("ovf_fetches", fetch_log.size() - f0, 1);
        check("ovf_err", err_ovf, 1);
`endif
        if (fetch_log.size() > f0) check("ovf_adr0", fetch_log[f0], 21'h1FFFFF);
        check("ovf_done", n_done - d0, 1);

        // Random scans with random strobes, TAP states, aborts, resets and stray go pulses.
        for (int s = 0; s < 60; s++) begin
            a = ($urandom_range(0, 3) == 0) ? 21'h1FFFFF - 21'($urandom_range(0, 3)) : 21'($urandom);
            l = 24'($urandom_range(1, 40));
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 150)) : -1;
            rst_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 150)) : -1;
            state = TAP_SHDR;
            pulse_go(a, l);
            k = 0;
            while (busy && k < 3000) begin
                reset = 1'b0;
                case ($urandom_range(0, 9))
                    0:       state = TAP_PADR;
                    1:       state = TAP_E1DR;
                    2, 3, 4: state = TAP_SHIR;
                    default: state = TAP_SHDR;
                endcase
                if (k == abort_at) state = TAP_TLR;
                if (k == rst_at) reset = 1'b1;
                shift_strb = ($urandom_range(0, 2) == 0);
                go         = ($urandom_range(0, 19) == 0);
                start_adr  = 21'($urandom);
                cyc();
                k++;
            end
            shift_strb = 1'b0; go = 1'b0; reset = 1'b0; state = TAP_SHDR;
            check("rand_idle", busy, 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_addr_gen.md
# vec_addr_gen

Byte-address generator and TDO bit server for the executor's vector RAM. Upstream of the RAM address/data mux: it drives `a_ag[23:3]` and `tdo_req`, which the mux routes to the RAM in scan mode. It latches each returned byte from the mux data output and presents it bit by bit while the TAP is in Shift-DR/Shift-IR.

## Interface
- `RD_WAIT`, 2: clock cycles `tdo_req` is held before the RAM byte is sampled (1..7).
- `clk` in 1: system clock.
- `reset` in 1: reset; synchronous, active-high.
- `state` in 4: current TAP state, same 4-bit encoding as the TAP controller (shdr=6, shir=7, tlr=0).
- `start_adr` in 21: first byte address of the vector.
- `bit_len` in 24: number of bits to shift; 0 is illegal.
- `go` in 1: one-cycle start pulse.
- `shift_strb` in 1: one-cycle pulse per TCK bit; consumes the current bit.
- `d_mux` in 8: RAM byte from the mux.
- `a_ag` out 21 [23:3]: RAM byte address.
- `tdo_req` out 1: RAM read request, active-high.
- `tdo_bit` out 1: current bit to TDO, LSB first.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan end.
- `err_urun` out 1: sticky; a strobe arrived while a fetch was pending.
- `err_ovf` out 1: sticky; address overflow (only when the wrap feature is compiled out).

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- **IDLE**
  - `go` loads `a_ag` from `start_adr` and the bit counter from `bit_len`.
  - It clears `err_urun` and `err_ovf`, then moves to FETCH.
  - `go` while `busy` is ignored.
- **FETCH**
  - `tdo_req` = 1 for exactly `RD_WAIT` cycles (wait counter).
  - On the last cycle, `d_mux` is latched into an 8-bit byte register, `bit_sel` is set to 0, and the FSM moves to SHIFT.
- **SHIFT**
  - `tdo_bit` = `byte[bit_sel]`.
  - A `shift_strb` with `state` equal to shdr or shir decrements the bit counter and increments `bit_sel`.
  - A strobe in any other TAP state is ignored.
  - When the counter reaches 0, go to DONE.
  - Otherwise, when `bit_sel` wraps 7→0, increment `a_ag` and go to FETCH.
- **DONE**: `done` = 1 for one cycle, then IDLE.
- **Underrun**: `shift_strb` during FETCH sets `err_urun`. The strobe is dropped, not queued, and the counter is not changed.
- **Abort**: `state` equal to tlr while busy returns the FSM to IDLE next cycle. `tdo_req` deasserts and there is no `done` pulse.
- **Overflow**: incrementing `a_ag` from 21'h1FFFFF behaves per Configuration.
- **Address arithmetic**: 21-bit unsigned; `bit_len` counter is 24-bit unsigned.
- **Byte fetch count**: ceil(`bit_len`/8). The last byte may be partially used; its unused bits are never presented.

## Timing
- Reset values: `a_ag`=0, `tdo_req`=0, `tdo_bit`=0, `busy`=0, `done`=0, `err_urun`=0, `err_ovf`=0. FSM=IDLE, byte register=0.
- `reset` mid-scan aborts with no `done` pulse.
- `a_ag` changes only on the cycle entering FETCH. It is stable for the whole `tdo_req` window.
- `go` at edge N: `busy`=1 and `tdo_req`=1 from N+1. The byte is latched at edge N+`RD_WAIT`. `tdo_bit` is valid from N+`RD_WAIT`+1.
- `tdo_bit` updates the cycle after each accepted `shift_strb`.
- Strobe spacing: the 8th strobe of a byte must be followed by ≥`RD_WAIT`+1 cycles before the next strobe, or `err_urun` is set.
- If the final strobe and an abort (tlr) coincide, the abort wins.
- If `shift_strb` and `go` coincide in IDLE, the strobe is ignored.

## Configuration
- `VEC_ADDR_WRAP_EN` defined: `a_ag` wraps 21'h1FFFFF→0 and the scan continues; `err_ovf` is tied to 0.
- `VEC_ADDR_WRAP_EN` undefined: an increment past 21'h1FFFFF sets `err_ovf`, skips the fetch, and goes to DONE (`done` still pulses).

## Structure
- The shared executor package holds:
  - TAP state encodings (tlr..upir, 4-bit).
  - FSM state typedef.
  - `ADR_W`=21 and `LEN_W`=24.
- One natural sub-module, `vec_fetch_timer`: the `RD_WAIT` down-counter producing `tdo_req` and a sample strobe.

## Test plan
- **Basic scan**:
  - Stimulus: `start_adr`=0x00010, `bit_len`=12, RAM[0x10]=0xA5, RAM[0x11]=0x0C, strobes every 6 cycles in shdr.
  - Response: `tdo_bit` sequence 1,0,1,0,0,1,0,1,0,0,1,1; exactly two fetches at 0x10 and 0x11; one `done`.
- **Underrun**:
  - Stimulus: `RD_WAIT`=2, `bit_len`=16, a strobe 1 cycle after the 8th.
  - Response: `err_urun`=1; the counter still needs 8 more strobes; `done` after the 16th accepted strobe.
- **Abort**:
  - Stimulus: `state`=tlr after 5 strobes of a 20-bit scan.
  - Response: `busy`=0 next cycle, `tdo_req`=0, no `done`; a later `go` restarts at `start_adr`.
- **Overflow**:
  - Stimulus: `start_adr`=0x1FFFFF, `bit_len`=16.
  - Response with macro: second fetch at 0x000000.
  - Response without macro: `err_ovf`=1 after 8 bits, `done` pulses, and there is no second fetch.
- **Strobe gating**: strobes with `state`=padr (0xA) -> counter and `tdo_bit` unchanged.
- **Reset mid-fetch**: `reset` during `tdo_req` -> all outputs return to reset values next edge.
